// File: rtl/mcu_fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/grant/response side plus
// the decode-side instruction stream and redirect.
interface mcu_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Handshakes: a request transfers on a cycle where imem_req & imem_gnt;
    // responses (imem_rvalid) return in request order at most one per cycle;
    // an instruction transfers to decode on a cycle where instr_valid & instr_ready.
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] instr_pcplus4;
    logic            instr_ready;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   queue_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc, instr_pcplus4, queue_count,
        input  instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc, instr_pcplus4, queue_count,
        output instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/mcu_fetch_queue.sv
// Instruction-fetch front end: credit-limited memory requests, DEPTH-entry prefetch
// queue and redirect flush. Define FETCH_BYPASS_EN for a zero-latency empty-queue bypass.
module mcu_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               reset,
    mcu_fetch_queue_if.master bus
);
    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [31:0]     q_instr_q [DEPTH];
    logic [XLEN-1:0] q_pc_q    [DEPTH];

    logic [CW:0]     credit_used;
    logic            req;
    logic            grant;
    logic            accept;
    logic            drop;
    logic            push;
    logic            pop;
    logic            queue_empty;
    logic            bypass_take;
    logic            head_valid;
    logic [31:0]     head_instr;
    logic [XLEN-1:0] head_pc;

    // Stale in-flight responses will never land in the queue, so they free credit.
    always_comb begin
        credit_used = {1'b0, count_q} + {1'b0, outst_q} - {1'b0, discard_q};
        req         = (credit_used < DEPTH_W);
        grant       = req & bus.imem_gnt;
        queue_empty = (count_q == '0);
        drop        = bus.imem_rvalid & (discard_q != '0);
        accept      = bus.imem_rvalid & (discard_q == '0);
        head_valid  = !queue_empty;
        head_instr  = q_instr_q[head_q];
        head_pc     = q_pc_q[head_q];
        bypass_take = 1'b0;
`ifdef FETCH_BYPASS_EN
        if (queue_empty && accept && !bus.redirect_valid) begin
            head_valid  = 1'b1;
            head_instr  = bus.imem_rdata;
            head_pc     = resp_pc_q;
            bypass_take = bus.instr_ready;
        end
`else
        bypass_take = 1'b0;
`endif
        push = accept & !bypass_take & !bus.redirect_valid;
        pop  = !queue_empty & bus.instr_ready & !bus.redirect_valid;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        if (grant) outst_d = outst_d + CNT_ONE;
        if (bus.imem_rvalid) outst_d = outst_d - CNT_ONE;
        if (bus.redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            discard_d  = outst_d;
        end else begin
            if (grant)  fetch_pc_d = fetch_pc_q + PC_STEP;
            if (drop)   discard_d  = discard_q - CNT_ONE;
            if (accept) resp_pc_d  = resp_pc_q + PC_STEP;
            if (push)   tail_d     = tail_q + PTR_ONE;
            if (pop)    head_d     = head_q + PTR_ONE;
            if (push && !pop)      count_d = count_q + CNT_ONE;
            else if (pop && !push) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_q[i] <= '0;
                q_pc_q[i]    <= RESET_PC;
            end
        end else if (push) begin
            q_instr_q[tail_q] <= bus.imem_rdata;
            q_pc_q[tail_q]    <= resp_pc_q;
        end
    end

    assign bus.imem_req      = req;
    assign bus.imem_addr     = fetch_pc_q;
    assign bus.instr_valid   = head_valid;
    assign bus.instr         = head_instr;
    assign bus.instr_pc      = head_pc;
    assign bus.instr_pcplus4 = head_pc + PC_STEP;
    assign bus.queue_count   = count_q;
endmodule

// File: tb/tb_mcu_fetch_queue.sv
// Directed bench for mcu_fetch_queue: memory responder with programmable latency,
// expected-PC scoreboard on every decode pop, and per-scenario point checks.
module tb_mcu_fetch_queue;
    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mcu_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    mcu_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          lat_k = 1;
    int          grant_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Account for the transfers of the current cycle, then advance one clock.
    task automatic tick();
        int          due;
        logic [31:0] e;
        logic [31:0] p4;
        #1;
        if (reset) begin
            if (bus.imem_req && bus.imem_gnt) begin
                due = cyc + lat_k;
                if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
                pend_addr.push_back(bus.imem_addr);
                pend_due.push_back(due);
                grant_cnt++;
            end
            if (bus.imem_rvalid) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
                check_eq("pop_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    p4 = e + 32'd4;
                    check_eq("pop_pc", bus.instr_pc, e);
                    check_eq("pop_instr", bus.instr, mem_word(e));
                    check_eq("pop_pcplus4", bus.instr_pcplus4, p4);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(pend_addr[0]);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        tick();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
    endtask

    task automatic wait_valid(input string tag, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            if (bus.instr_valid) seen = 1'b1;
            else tick();
        end
        check_eq(tag, seen, 1);
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        pend_addr.delete();
        pend_due.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_req", bus.imem_req, 1);
        check_eq("rst_addr", bus.imem_addr, RESET_PC);
        check_eq("rst_valid", bus.instr_valid, 0);
        check_eq("rst_instr", bus.instr, 0);
        check_eq("rst_pc", bus.instr_pc, RESET_PC);
        check_eq("rst_pcplus4", bus.instr_pcplus4, 32'h4);
        check_eq("rst_count", bus.queue_count, 0);
        reset = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        do_reset();

        // Streaming: gnt=1, k=1, ready=1.
        lat_k = 1;
        bus.imem_gnt    = 1'b1;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        for (int i = 0; i < 8; i++) begin
            check_eq("t1_addr", bus.imem_addr, 32'(4 * i));
`ifdef FETCH_BYPASS_EN
            if (i == 1) begin
                check_eq("t1_valid_c1", bus.instr_valid, 1);
                check_eq("t1_pc_c1", bus.instr_pc, 32'h0);
            end
`else
            if (i == 1) check_eq("t1_valid_c1", bus.instr_valid, 0);
            if (i == 2) begin
                check_eq("t1_valid_c2", bus.instr_valid, 1);
                check_eq("t1_pc_c2", bus.instr_pc, 32'h0);
            end
`endif
            tick();
        end
        bus.imem_gnt = 1'b0;
        ticks(4);
        check_eq("t1_drained_count", bus.queue_count, 0);
        check_eq("t1_drained_exp", exp_q.size(), 0);

        // Back-pressure: exactly DEPTH grants, then one pop frees one credit.
        bus.imem_gnt    = 1'b1;
        bus.instr_ready = 1'b0;
        grant_cnt = 0;
        ticks(10);
        check_eq("t2_grants", grant_cnt, 4);
        check_eq("t2_req_low", bus.imem_req, 0);
        check_eq("t2_count_full", bus.queue_count, 4);
        exp_q.push_back(32'h20);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        grant_cnt = 0;
        ticks(6);
        check_eq("t2_regrant", grant_cnt, 1);
        check_eq("t2_count_refull", bus.queue_count, 4);
        check_eq("t2_req_low2", bus.imem_req, 0);
        check_eq("t2_one_pop", exp_q.size(), 0);
        exp_q.push_back(32'h24);
        exp_q.push_back(32'h28);
        exp_q.push_back(32'h2C);
        exp_q.push_back(32'h30);
        bus.imem_gnt    = 1'b0;
        bus.instr_ready = 1'b1;
        ticks(6);
        check_eq("t2_drained_count", bus.queue_count, 0);
        check_eq("t2_drained_exp", exp_q.size(), 0);

        // k=3 with two outstanding, redirect to 0x100.
        lat_k = 3;
        check_eq("t3_start_addr", bus.imem_addr, 32'h34);
        bus.imem_gnt = 1'b1;
        ticks(2);
        bus.imem_gnt = 1'b0;
        redirect_to(32'h100);
        check_eq("t3_redir_addr", bus.imem_addr, 32'h100);
        check_eq("t3_valid_after", bus.instr_valid, 0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        check_eq("t3_count_a", bus.queue_count, 0);
        bus.imem_gnt = 1'b1;
        tick();
        check_eq("t3_count_b", bus.queue_count, 0);
        tick();
        bus.imem_gnt = 1'b0;
        check_eq("t3_count_c", bus.queue_count, 0);
        wait_valid("t3_wait_valid", seen);
        if (seen) begin
            check_eq("t3_first_pc", bus.instr_pc, 32'h100);
            check_eq("t3_first_pcplus4", bus.instr_pcplus4, 32'h104);
        end
        ticks(8);
        check_eq("t3_drained_exp", exp_q.size(), 0);
        check_eq("t3_drained_count", bus.queue_count, 0);

        // Redirect in the same cycle as the grant of 0x0C.
        lat_k = 1;
        bus.instr_ready = 1'b0;
        redirect_to(32'h4);
        bus.imem_gnt = 1'b1;
        ticks(2);
        check_eq("t4_addr_0c", bus.imem_addr, 32'hC);
        redirect_to(32'h200);
        check_eq("t4_redir_addr", bus.imem_addr, 32'h200);
        check_eq("t4_count_a", bus.queue_count, 0);
        exp_q.push_back(32'h200);
        exp_q.push_back(32'h204);
        bus.instr_ready = 1'b1;
        tick();
        check_eq("t4_count_b", bus.queue_count, 0);
        tick();
        bus.imem_gnt = 1'b0;
        wait_valid("t4_wait_valid", seen);
        if (seen) check_eq("t4_first_pc", bus.instr_pc, 32'h200);
        ticks(6);
        check_eq("t4_drained_exp", exp_q.size(), 0);

        // Address wrap at 2^XLEN.
        redirect_to(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        bus.imem_gnt = 1'b1;
        check_eq("t5_addr_f8", bus.imem_addr, 32'hFFFF_FFF8);
        tick();
        check_eq("t5_addr_fc", bus.imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("t5_wrap_addr", bus.imem_addr, 32'h0);
        tick();
        check_eq("t5_addr_4", bus.imem_addr, 32'h4);
        tick();
        bus.imem_gnt = 1'b0;
        ticks(6);
        check_eq("t5_drained_exp", exp_q.size(), 0);

        // Single response into an empty queue: latency check.
        check_eq("t6_start_addr", bus.imem_addr, 32'h8);
        exp_q.push_back(32'h8);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        check_eq("t6_rvalid", bus.imem_rvalid, 1);
`ifdef FETCH_BYPASS_EN
        check_eq("t6_byp_valid", bus.instr_valid, 1);
        check_eq("t6_byp_pc", bus.instr_pc, 32'h8);
        check_eq("t6_byp_instr", bus.instr, mem_word(32'h8));
        check_eq("t6_byp_count", bus.queue_count, 0);
        tick();
        check_eq("t6_byp_count_after", bus.queue_count, 0);
        check_eq("t6_byp_valid_after", bus.instr_valid, 0);
`else
        check_eq("t6_valid_resp_cycle", bus.instr_valid, 0);
        check_eq("t6_count_resp_cycle", bus.queue_count, 0);
        tick();
        check_eq("t6_valid_next", bus.instr_valid, 1);
        check_eq("t6_pc_next", bus.instr_pc, 32'h8);
        check_eq("t6_count_next", bus.queue_count, 1);
`endif
        ticks(3);
        check_eq("t6_drained_exp", exp_q.size(), 0);

        // Reset in the middle of traffic.
        bus.instr_ready = 1'b0;
        bus.imem_gnt    = 1'b1;
        ticks(4);
        check_eq("t7_fill_count", bus.queue_count, 3);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mcu_fetch_queue.md
# mcu_fetch_queue

Parametrised instruction-fetch front end for the MCU's five-stage pipeline. It replaces the single fetch PC register and combinational instruction-memory read with a request/grant/response memory handshake, a DEPTH-entry prefetch queue, and redirect handling for branches and jumps. It sits between instruction memory and the decode-stage register. Decode consumes instructions through a valid/ready pair, where ready = !StallD.

## Interface
- XLEN, 32: PC and address width (≥16).
- DEPTH, 4: prefetch queue entries; power of two, ≥2.
- RESET_PC, 0: fetch address after reset.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address (word aligned).
- imem_gnt  in  1  request accepted this cycle (handshake is imem_req & imem_gnt).
- imem_rvalid  in  1  response valid; responses arrive in request order, one per cycle max, ≥1 cycle after grant.
- imem_rdata  in  32  response instruction.
- instr_valid  out  1  queue head valid.
- instr  out  32  head instruction.
- instr_pc  out  XLEN  head instruction PC.
- instr_pcplus4  out  XLEN  instr_pc + 4, modulo 2^XLEN.
- instr_ready  in  1  decode accepts head (pop = instr_valid & instr_ready).
- redirect_valid  in  1  branch/jump taken in decode.
- redirect_pc  in  XLEN  new fetch target.
- queue_count  out  clog2(DEPTH)+1  occupied entries.

## Operation
- Internal state:
  - fetch_pc (drives imem_addr).
  - resp_pc: PC of the next accepted response.
  - FIFO of {instr, pc} with head/tail pointers of clog2(DEPTH) bits (natural wrap).
  - count.
  - outstanding: granted, not yet returned; 0..DEPTH.
  - discard: stale responses still to drop; 0..DEPTH.
- Credit rule: imem_req = (count + outstanding − discard < DEPTH). This is independent of redirect_valid, so there is no combinational path from redirect.
- Grant: fetch_pc += 4 (wraps at 2^XLEN); outstanding += 1.
- Response:
  - outstanding −= 1.
  - If discard > 0: discard −= 1 and the data is dropped.
  - Otherwise: push {imem_rdata, resp_pc} and resp_pc += 4.
- Pop: head advances; count −= 1.
- Push and pop in the same cycle: count unchanged.
- Redirect (highest priority) in cycle t:
  - Queue emptied (count = 0, head = tail).
  - fetch_pc and resp_pc := redirect_pc.
  - discard := outstanding after that cycle's grant/response updates. A request granted in cycle t is therefore stale. A response arriving in cycle t is dropped.
  - A pop in cycle t is ignored.
- Overflow is impossible by the credit rule. Grant while full is impossible because imem_req is low.
- Reset values:
  - imem_req = 1.
  - imem_addr = RESET_PC.
  - instr_valid = 0, instr = 0, instr_pc = RESET_PC.
  - queue_count = 0; outstanding = discard = 0.
- Reset mid-operation clears all state. Instruction memory shares this reset, so pre-reset responses never arrive.

## Timing
- Grant in cycle t; response in cycle t+k (k ≥ 1).
  - Without bypass: instr_valid rises in cycle t+k+1.
- Redirect in cycle t:
  - imem_addr = redirect_pc from t+1.
  - instr_valid = 0 in t+1.
  - The first valid instruction has pc = redirect_pc.
- Steady state with k = 1, always-grant, always-ready: one instruction per cycle.
- Queue storage is registered. instr, instr_pc and instr_valid are driven from flops (except under bypass, see below).

## Configuration
- FETCH_BYPASS_EN defined:
  - When count = 0 and a non-discarded response arrives, imem_rdata and resp_pc drive instr/instr_pc in the same cycle, and instr_valid = 1.
  - If instr_ready = 1 that cycle, the entry is consumed without a push (count stays 0). Otherwise it is pushed.
  - Response-to-decode latency is 0 cycles. redirect_valid still suppresses the bypass.
- Undefined: every response goes through the queue; latency is 1 cycle; all outputs come from flops.

## Test plan
- Reset release, gnt = 1, k = 1, ready = 1 → imem_addr 0x0, 0x4, 0x8… on consecutive cycles; instr_pc 0x0, 0x4, 0x8 from the third cycle; instr matches memory contents.
- ready = 0, DEPTH = 4, k = 1 → exactly 4 grants; imem_req falls; queue_count = 4. Releasing ready for one cycle → one pop, one new grant, no overflow.
- k = 3 with 2 outstanding; redirect to 0x100 → both stale responses dropped (queue_count stays 0); first instr_valid has instr_pc = 0x100, instr_pcplus4 = 0x104.
- Redirect to 0x200 in the same cycle as the grant of 0x0C → the 0x0C response is dropped; the next instruction has pc 0x200.
- fetch_pc = 0xFFFFFFFC granted → next imem_addr = 0x00000000; instr_pcplus4 of that entry = 0x0.
- FETCH_BYPASS_EN, empty queue, rvalid with ready = 1 → instr_valid = 1 in the response cycle; queue_count remains 0.
